// File: rtl/uart_rx_ctrl.sv
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive controller; frames serial_in using an external bit
//             timer, loads rx_data and flags framing / overrun errors.
//  Options  : define UART_RX_START_CHECK_EN to re-sample the start bit at its
//             centre and abandon false starts.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        serial_in,
   input  logic [3:0]  data_size,
   input  logic [13:0] bit_period,
   input  logic        shift_strobe,
   input  logic        packet_done,
   output logic        enable_timer,
   input  logic        data_read,
   output logic [7:0]  rx_data,
   output logic        data_ready,
   output logic        framing_error,
   output logic        overrun_error
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_START   = 2'd1;
   localparam logic [1:0] ST_RECEIVE = 2'd2;
   localparam logic [1:0] ST_LOAD    = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [13:0]            half_cnt_q, half_cnt_d;
   logic [8:0]             shreg_q, shreg_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   data_ready_q, data_ready_d;
   logic                   framing_error_q, framing_error_d;
   logic                   overrun_error_q, overrun_error_d;

   logic                   line;
   logic                   start_det;
   logic                   half_done;
   logic                   start_entry;
   logic [3:0]             drop_bits;
   logic [7:0]             load_data;
   logic                   load_stop;
   logic                   load_ok;
   logic                   load_bad;

   assign line = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_det) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (half_done) begin
`ifdef UART_RX_START_CHECK_EN
               state_d = line ? ST_IDLE : ST_RECEIVE;
`else
               state_d = ST_RECEIVE;
`endif
            end
         end
         ST_RECEIVE: begin
            if (packet_done) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      enable_timer = 1'b0;
      if (state_q == ST_RECEIVE) begin
         enable_timer = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], serial_in};
      hist_d      = line;
      start_det   = (state_q == ST_IDLE) && hist_q && !line;
      half_done   = (state_q == ST_START) && (half_cnt_q == ((bit_period >> 1) - 14'd1));
      start_entry = (state_q == ST_IDLE) && (state_d == ST_START);

      half_cnt_d = 14'd0;
      if ((state_q == ST_START) && !half_done) begin
         half_cnt_d = half_cnt_q + 14'd1;
      end

      shreg_d = shreg_q;
      if ((state_q == ST_RECEIVE) && shift_strobe) begin
         shreg_d = {line, shreg_q[8:1]};
      end

      // Short frames leave their LSB at bit 8-data_size; realign to bit 0.
      drop_bits = 4'd8 - data_size;
      load_data = shreg_q[7:0] >> drop_bits;
      load_stop = shreg_q[8];
      load_ok   = (state_q == ST_LOAD) && load_stop;
      load_bad  = (state_q == ST_LOAD) && !load_stop;

      rx_data_d       = rx_data_q;
      data_ready_d    = data_ready_q;
      overrun_error_d = overrun_error_q;
      if (load_ok) begin
         rx_data_d    = load_data;
         data_ready_d = 1'b1;
         if (data_ready_q && !data_read) begin
            overrun_error_d = 1'b1;
         end
      end else if (data_read) begin
         data_ready_d    = 1'b0;
         overrun_error_d = 1'b0;
      end

      framing_error_d = framing_error_q;
      if (start_entry) begin
         framing_error_d = 1'b0;
      end else if (load_bad) begin
         framing_error_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (n_rst) begin
         sync_q          <= '1;
         hist_q          <= 1'b1;
         half_cnt_q      <= 14'd0;
         shreg_q         <= 9'd0;
         rx_data_q       <= 8'h00;
         data_ready_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         sync_q          <= sync_d;
         hist_q          <= hist_d;
         half_cnt_q      <= half_cnt_d;
         shreg_q         <= shreg_d;
         rx_data_q       <= rx_data_d;
         data_ready_q    <= data_ready_d;
         framing_error_q <= framing_error_d;
         overrun_error_q <= overrun_error_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign data_ready    = data_ready_q;
   assign framing_error = framing_error_q;
   assign overrun_error = overrun_error_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl with a behavioural bit
//             timer, frame-level reference model and random frames.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        serial_in = 1'b1;
   logic [3:0]  data_size = 4'd8;
   logic [13:0] bit_period = 14'd10;
   logic        shift_strobe = 1'b0;
   logic        packet_done = 1'b0;
   logic        data_read = 1'b0;
   logic        enable_timer;
   logic [7:0]  rx_data;
   logic        data_ready;
   logic        framing_error;
   logic        overrun_error;

   int checks = 0;
   int errors = 0;

   // Reference model: what the outputs must be after each completed frame.
   logic [7:0]  exp_rx  = 8'h00;
   logic        exp_dr  = 1'b0;
   logic        exp_fe  = 1'b0;
   logic        exp_ovr = 1'b0;
   logic        exp_en  = 1'b0;
   logic        chk_on  = 1'b0;
   logic        chk_en_on = 1'b0;
   logic        en_seen = 1'b0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.SYNC_STAGES(2)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .serial_in     (serial_in),
      .data_size     (data_size),
      .bit_period    (bit_period),
      .shift_strobe  (shift_strobe),
      .packet_done   (packet_done),
      .enable_timer  (enable_timer),
      .data_read     (data_read),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun_error (overrun_error)
   );

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison against the model whenever outputs are settled.
   always @(posedge clk) begin
      #2;
      if (enable_timer === 1'b1) en_seen = 1'b1;
      if (chk_on) begin
         cmp("rx_data", rx_data, exp_rx);
         cmp("data_ready", {7'd0, data_ready}, {7'd0, exp_dr});
         cmp("framing_error", {7'd0, framing_error}, {7'd0, exp_fe});
         cmp("overrun_error", {7'd0, overrun_error}, {7'd0, exp_ovr});
      end
      if (chk_en_on) cmp("enable_timer", {7'd0, enable_timer}, {7'd0, exp_en});
   end

   // Behavioural bit timer: strobe every bit_period enabled cycles,
   // packet_done one cycle after the (data_size+1)th strobe.
   initial begin
      int  cnt;
      int  nstr;
      logic pend;
      cnt = 0; nstr = 0; pend = 1'b0;
      forever begin
         @(negedge clk);
         shift_strobe = 1'b0;
         packet_done  = 1'b0;
         if (enable_timer !== 1'b1) begin
            cnt = 0; nstr = 0; pend = 1'b0;
         end else begin
            if (pend) begin
               packet_done = 1'b1;
               pend = 1'b0;
            end
            cnt++;
            if (cnt == int'(bit_period)) begin
               shift_strobe = 1'b1;
               cnt = 0;
               nstr++;
               if (nstr == int'(data_size) + 1) pend = 1'b1;
            end
         end
      end
   end

   function automatic logic [7:0] size_mask(input logic [3:0] ds);
      logic [7:0] m;
      m = 8'hFF;
      return m >> (8 - int'(ds));
   endfunction

   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (stop) begin
         if (exp_dr) exp_ovr = 1'b1;
         exp_rx = d & size_mask(data_size);
         exp_dr = 1'b1;
      end else begin
         exp_fe = 1'b1;
      end
   endtask

   // Called at a negedge; returns at a negedge with the frame fully settled.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      chk_on = 1'b0; chk_en_on = 1'b0;
      exp_fe = 1'b0;
      serial_in = 1'b0;
      repeat (int'(bit_period)) @(negedge clk);
      for (int i = 0; i < int'(data_size); i++) begin
         serial_in = d[i];
         if (i == 0) begin
            exp_en = 1'b1; chk_en_on = 1'b1; chk_on = 1'b1;
         end
         repeat (int'(bit_period)) @(negedge clk);
      end
      chk_on = 1'b0; chk_en_on = 1'b0;
      serial_in = stop;
      repeat (int'(bit_period)) @(negedge clk);
      serial_in = 1'b1;
      repeat (6) @(negedge clk);
      model_frame(d, stop);
      exp_en = 1'b0; chk_on = 1'b1; chk_en_on = 1'b1;
   endtask

   task automatic do_read();
      data_read = 1'b1;
      exp_dr = 1'b0; exp_ovr = 1'b0;
      @(negedge clk);
      data_read = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rd;
      repeat (3) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      chk_on = 1'b1; chk_en_on = 1'b1; exp_en = 1'b0;
      cmp("reset rx_data", rx_data, 8'h00);
      cmp("reset flags", {4'd0, enable_timer, data_ready, framing_error, overrun_error}, 8'h00);
      repeat (4) @(negedge clk);

      // 0xA5, 8 bits, bit_period 10
      send_frame(8'hA5, 1'b1);
      cmp("A5 rx_data", rx_data, 8'hA5);
      cmp("A5 flags", {5'd0, data_ready, framing_error, overrun_error}, 8'b100);
      do_read();

      // 5-bit frame
      data_size = 4'd5;
      @(negedge clk);
      send_frame(8'h15, 1'b1);
      cmp("5bit rx_data", rx_data, 8'h15);
      do_read();

      // framing error
      data_size = 4'd8;
      @(negedge clk);
      send_frame(8'h3C, 1'b0);
      cmp("fe rx_data", rx_data, 8'h15);
      cmp("fe flags", {5'd0, data_ready, framing_error, overrun_error}, 8'b010);
      repeat (3) @(negedge clk);

      // overrun
      send_frame(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      send_frame(8'h22, 1'b1);
      cmp("ovr rx_data", rx_data, 8'h22);
      cmp("ovr flags", {5'd0, data_ready, framing_error, overrun_error}, 8'b101);
      do_read();
      cmp("ovr read flags", {6'd0, data_ready, overrun_error}, 8'b00);

      // 3-cycle glitch
      chk_on = 1'b0; chk_en_on = 1'b0;
      en_seen = 1'b0;
      serial_in = 1'b0;
      repeat (3) @(negedge clk);
      serial_in = 1'b1;
      repeat (11 * int'(bit_period)) @(negedge clk);
`ifdef UART_RX_START_CHECK_EN
      cmp("glitch enable seen", {7'd0, en_seen}, 8'h00);
      cmp("glitch data_ready", {7'd0, data_ready}, 8'h00);
`else
      model_frame(8'hFF, 1'b1);
      cmp("glitch enable seen", {7'd0, en_seen}, 8'h01);
      cmp("glitch rx_data", rx_data, 8'hFF);
`endif
      chk_on = 1'b1; chk_en_on = 1'b1; exp_en = 1'b0;
      do_read();

      // reset during RECEIVE
      send_frame(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      chk_on = 1'b0; chk_en_on = 1'b0;
      serial_in = 1'b0;
      repeat (int'(bit_period)) @(negedge clk);
      rd = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         serial_in = rd[i];
         repeat (int'(bit_period)) @(negedge clk);
      end
      n_rst = 1'b1; serial_in = 1'b1;
      exp_rx = 8'h00; exp_dr = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0; exp_en = 1'b0;
      chk_on = 1'b1; chk_en_on = 1'b1;
      @(negedge clk);
      n_rst = 1'b0;
      cmp("mid reset rx_data", rx_data, 8'h00);
      cmp("mid reset flags", {4'd0, enable_timer, data_ready, framing_error, overrun_error}, 8'h00);
      repeat (2 * int'(bit_period)) @(negedge clk);
      send_frame(8'h5A, 1'b1);
      cmp("post reset rx_data", rx_data, 8'h5A);
      cmp("post reset data_ready", {7'd0, data_ready}, 8'h01);

      // random frames
      for (int n = 0; n < 30; n++) begin
         data_size  = 4'($urandom_range(8, 5));
         bit_period = 14'($urandom_range(40, 10));
         repeat (2) @(negedge clk);
         if ($urandom_range(3, 0) == 0) do_read();
         rd = 8'($urandom);
         send_frame(rd, ($urandom_range(4, 0) != 0));
         repeat ($urandom_range(8, 1)) @(negedge clk);
      end

      chk_on = 1'b0; chk_en_on = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
